// File: rtl/fpadd_arbiter.sv
// Round-robin share of one combinational FP adder among NREQ requesters.
// Latency: accept edge T -> rsp_valid after edge T+EVAL_CYCLES; issue interval >= EVAL_CYCLES+2.
// Backpressure: result held in RESP until the owner's rsp_ready; no grants are issued meanwhile.
module fpadd_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 32,
    parameter int WCONTROL    = 5,
    parameter int WFLAG       = 5,
    parameter int EVAL_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    input  logic [NREQ*WCONTROL-1:0]  req_control,
    output logic [WIDTH-1:0]          fp_a,
    output logic [WIDTH-1:0]          fp_b,
    output logic [WCONTROL-1:0]       fp_control,
    input  logic [WIDTH-1:0]          fp_result,
    input  logic [WFLAG-1:0]          fp_flags,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [WIDTH-1:0]          rsp_result,
    output logic [WFLAG-1:0]          rsp_flags,
    output logic                      busy,
    output logic [WFLAG-1:0]          sticky_flags,
    input  logic                      flags_clr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      fp_a_q, fp_a_d;
    logic [WIDTH-1:0]      fp_b_q, fp_b_d;
    logic [WCONTROL-1:0]   fp_control_q, fp_control_d;
    logic [WIDTH-1:0]      rsp_result_q, rsp_result_d;
    logic [WFLAG-1:0]      rsp_flags_q, rsp_flags_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [WFLAG-1:0]      sticky_q, sticky_d;

    logic                  grant_vld;
    logic [PW-1:0]         grant_idx;
    logic [PW:0]           sum;

    // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            if (req_valid[sum[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        fp_a_d       = fp_a_q;
        fp_b_d       = fp_b_q;
        fp_control_d = fp_control_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        sticky_d     = flags_clr ? '0 : sticky_q;
        req_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    fp_a_d       = req_a[grant_idx*WIDTH +: WIDTH];
                    fp_b_d       = req_b[grant_idx*WIDTH +: WIDTH];
                    fp_control_d = req_control[grant_idx*WCONTROL +: WCONTROL];
                    owner_d      = grant_idx;
                    rr_ptr_d     = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
                    cnt_d        = CNT_INIT;
                    state_d      = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (cnt_q == '0) begin
                    rsp_result_d         = fp_result;
                    rsp_flags_d          = fp_flags;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    // A clear in the capture cycle still keeps the freshly captured flags.
                    sticky_d             = sticky_d | fp_flags;
                    state_d              = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            fp_a_q       <= '0;
            fp_b_q       <= '0;
            fp_control_q <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= '0;
            sticky_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            fp_a_q       <= fp_a_d;
            fp_b_q       <= fp_b_d;
            fp_control_q <= fp_control_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
            sticky_q     <= sticky_d;
        end
    end

    assign fp_a         = fp_a_q;
    assign fp_b         = fp_b_q;
    assign fp_control   = fp_control_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign sticky_flags = sticky_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: behavioural adder stand-in, accept-time scoreboard, directed scenarios.
module tb_fpadd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int WC   = 5;
    localparam int WF   = 5;
    localparam int EVAL = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [NREQ*WC-1:0]   req_control;
    logic [W-1:0]         fp_a, fp_b;
    logic [WC-1:0]        fp_control;
    logic [W-1:0]         fp_result;
    logic [WF-1:0]        fp_flags;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [W-1:0]         rsp_result;
    logic [WF-1:0]        rsp_flags;
    logic                 busy;
    logic [WF-1:0]        sticky_flags;
    logic                 flags_clr;

    fpadd_arbiter #(
        .NREQ(NREQ), .WIDTH(W), .WCONTROL(WC), .WFLAG(WF), .EVAL_CYCLES(EVAL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_control(req_control),
        .fp_a(fp_a), .fp_b(fp_b), .fp_control(fp_control),
        .fp_result(fp_result), .fp_flags(fp_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .sticky_flags(sticky_flags), .flags_clr(flags_clr)
    );

    always #5 clk = ~clk;

    // Adder stand-in: exact IEEE values for the known operand pairs, a deterministic mix otherwise.
    function automatic logic [W-1:0] m_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic [WC-1:0] c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == '0) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h3F800000 && c == '0) return 32'h40000000;
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && c == '0) return 32'h7F800000;
        return (a + b) ^ {27'd0, c};
    endfunction

    function automatic logic [WF-1:0] m_flags(input logic [W-1:0] a, input logic [W-1:0] b, input logic [WC-1:0] c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == '0) return 5'b00000;
        if (a == 32'h3F800000 && b == 32'h3F800000 && c == '0) return 5'b00000;
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && c == '0) return 5'b00101;
        return a[4:0] ^ b[4:0] ^ c;
    endfunction

    always_comb begin
        fp_result = m_res(fp_a, fp_b, fp_control);
        fp_flags  = m_flags(fp_a, fp_b, fp_control);
    end

    typedef struct {
        int            owner;
        logic [W-1:0]  res;
        logic [WF-1:0] flg;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    bit   have_prev = 0;
    bit   ival_en = 0;
    logic [NREQ-1:0] prev_rsp = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push expectations on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        int   g;
        exp_t e;
        if (reset) begin
            prev_rsp  = '0;
            have_prev = 0;
        end else begin
            if ((req_valid & req_ready) != '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
                grant_log.push_back(g);
                e.owner = g;
                e.res   = m_res(req_a[g*W +: W], req_b[g*W +: W], req_control[g*WC +: WC]);
                e.flg   = m_flags(req_a[g*W +: W], req_b[g*W +: W], req_control[g*WC +: WC]);
                sb.push_back(e);
                if (ival_en && have_prev) chk("issue_interval", 64'(cyc - prev_acc), 64'(EVAL + 2));
                prev_acc  = cyc;
                have_prev = 1;
                acc_cyc   = cyc;
            end
            if (rsp_valid != '0 && prev_rsp == '0) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("rsp_owner", 64'(rsp_valid), 64'(1 << sb[0].owner));
                    chk("latency", 64'(cyc - acc_cyc), 64'(EVAL + 1));
                end
            end
            if ((rsp_valid & rsp_ready) != '0 && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_flags", 64'(rsp_flags), 64'(e.flg));
            end
            prev_rsp = rsp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        grant_log.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grant_log.size() < n && t < 200) begin
            tick();
            t++;
        end
        if (grant_log.size() < n) chk("timeout_grant", 64'(grant_log.size()), 64'(n));
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            tick();
            t++;
        end
        if (sb.size() != 0 || busy) chk("timeout_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [WC-1:0] c);
        req_a[r*W +: W]      = a;
        req_b[r*W +: W]      = b;
        req_control[r*WC +: WC] = c;
    endtask

    task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input bit clr_at_capture);
        int n;
        n = grant_log.size() + 1;
        set_req(r, a, b, '0);
        req_valid = '0;
        req_valid[r] = 1'b1;
        wait_grants(n);
        req_valid = '0;
        if (clr_at_capture) begin
            repeat (EVAL - 1) tick();
            flags_clr = 1'b1;
            tick();
            flags_clr = 1'b0;
        end
        drain();
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_control = '0;
        rsp_ready   = '1;
        flags_clr   = 1'b0;
        tick();
        do_reset();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fp_a", 64'(fp_a), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_sticky", 64'(sticky_flags), 64'd0);

        // Single op 1.0 + 2.0
        set_req(0, 32'h3F800000, 32'h40000000, '0);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        wait_grants(1);
        req_valid = '0;
        drain();
        chk("idle_fp_a_hold", 64'(fp_a), 64'h3F800000);
        chk("idle_fp_b_hold", 64'(fp_b), 64'h40000000);

        // Fairness with all requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h40000000 + i * 32'h00110000, 32'h00001234 * (i + 1), WC'(i * 5));
        ival_en   = 1;
        req_valid = '1;
        wait_grants(5);
        req_valid = '0;
        ival_en   = 0;
        drain();
        for (int i = 0; i < 5; i++)
            chk("rr_order", 64'(grant_log.size() > i ? grant_log[i] : -1), 64'(i % NREQ));

        // Back-pressure on requester 2
        do_reset();
        set_req(2, 32'h3F800000, 32'h40000000, '0);
        set_req(3, 32'h41000000, 32'h00000007, 5'h10);
        rsp_ready = 4'b1011;
        req_valid = 4'b1100;
        begin
            int t = 0;
            while (!rsp_valid[2] && t < 50) begin
                tick();
                t++;
            end
            if (!rsp_valid[2]) chk("timeout_bp_rsp", 64'(rsp_valid), 64'h4);
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_result", 64'(rsp_result), 64'h40400000);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = '1;
        req_valid = 4'b1000;
        tick();
        chk("bp_next_grant", 64'(req_ready), 64'h8);
        wait_grants(2);
        req_valid = '0;
        drain();

        // Sticky flags
        do_reset();
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0);
        chk("ovf_sticky", 64'(sticky_flags), 64'h05);
        run_op(0, 32'h3F800000, 32'h3F800000, 1);
        chk("clr_at_capture", 64'(sticky_flags), 64'h00);
        run_op(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0);
        chk("sticky_again", 64'(sticky_flags), 64'h05);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("clr_idle", 64'(sticky_flags), 64'h00);
        run_op(2, 32'h00000010, 32'h00000000, 0);
        chk("sticky_accum", 64'(sticky_flags), 64'h10);
        run_op(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 1);
        chk("clr_keeps_new", 64'(sticky_flags), 64'h05);

        // Reset in the middle of EVAL
        do_reset();
        set_req(2, 32'h12345678, 32'h0000FFFF, 5'h3);
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = '0;
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (8) tick();
        chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        grant_log.delete();
        req_valid = '1;
        #1;
        chk("mid_rst_rr0", 64'(req_ready), 64'h1);
        wait_grants(1);
        req_valid = '0;
        drain();

        // Pointer wrap
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h3F800000 + i, 32'h00000100 * i, '0);
        req_valid = 4'b1000;
        wait_grants(1);
        req_valid = '0;
        drain();
        req_valid = '1;
        wait_grants(2);
        req_valid = '0;
        drain();
        req_valid = '1;
        wait_grants(3);
        req_valid = '0;
        drain();
        chk("wrap_g0", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd3);
        chk("wrap_g1", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'd0);
        chk("wrap_g2", 64'(grant_log.size() > 2 ? grant_log[2] : -1), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
Shares one combinational single-precision FP adder (add/sub, IEEE rounding, 5-bit flag field) among NREQ requesters. Round-robin arbitration, operand/control registering, multicycle evaluation wait, result capture and per-requester response handshake. Also keeps a sticky OR of all exception flags for status readout. Sits between neuron/synapse update engines and the shared adder instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, FP word width
WCONTROL, 5, control field width ([1:0] roundmode, [2] undertrap, [3] overtrap, [4] op 0=add 1=sub)
WFLAG, 5, exception flag width
EVAL_CYCLES, 1, cycles the adder inputs are held stable before result capture (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  one-hot grant/accept
req_a  in  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand b, same packing
req_control  in  NREQ*WCONTROL  control field, same packing
fp_a  out  WIDTH  registered operand to adder
fp_b  out  WIDTH  registered operand to adder
fp_control  out  WCONTROL  registered control to adder
fp_result  in  WIDTH  adder result
fp_flags  in  WFLAG  adder exception flags
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  per-requester response accept
rsp_result  out  WIDTH  captured result
rsp_flags  out  WFLAG  captured flags
busy  out  1  high whenever state != IDLE
sticky_flags  out  WFLAG  OR of all captured flags since last clear
flags_clr  in  1  clears sticky_flags

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE; rr_ptr=0; eval counter=0; fp_a, fp_b, fp_control, rsp_result, rsp_flags, sticky_flags=0; rsp_valid=0; req_ready=0. Any in-flight operation is dropped; no response issued. Reset overrides all other inputs.
- States: IDLE, EVAL, RESP.
- IDLE: grant = first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ. req_ready = one-hot grant (combinational from req_valid; 0 if none valid, 0 outside IDLE). On accept (req_valid[g] & req_ready[g]): latch req_a/req_b/req_control slice g into fp_a/fp_b/fp_control; owner=g; rr_ptr=(g+1) mod NREQ; counter=EVAL_CYCLES-1; state->EVAL.
- EVAL: fp_* held constant. Counter decrements each cycle; in the cycle counter==0: rsp_result<=fp_result, rsp_flags<=fp_flags, rsp_valid[owner]<=1, sticky_flags<=(flags_clr ? 0 : sticky_flags) | fp_flags; state->RESP.
- RESP: rsp_valid one-hot at owner, rsp_result/rsp_flags stable. When rsp_ready[owner]=1: rsp_valid<=0, state->IDLE. rsp_ready of non-owners ignored.
- Latency: accept at edge T -> fp_* valid after T -> rsp_valid high after edge T+EVAL_CYCLES. Minimum issue interval EVAL_CYCLES+2 cycles (with rsp_ready held high).
- req_valid must stay high with stable operands until accepted; dropping it before accept is permitted and simply withdraws the request.
- fp_* retain last operation's values in IDLE (no toggling when idle).
- flags_clr outside the capture cycle: sticky_flags<=0. Same cycle as capture: cleared, then new fp_flags OR'd in (new flags survive).
- rr_ptr wrap: grant to NREQ-1 sets rr_ptr=0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 operations.

Test Plan:
- Single op: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), control=0x00 -> req_ready[0] same cycle; rsp_valid[0] after EVAL_CYCLES+1 edges, rsp_result=0x40400000, rsp_flags=0.
- All four valid constantly, rsp_ready=4'hF -> grant order 0,1,2,3,0; each rsp_valid one-hot to matching owner; issue interval exactly EVAL_CYCLES+2.
- Back-pressure: rsp_ready[2]=0 for 10 cycles after rsp_valid[2] -> rsp_result stable, busy=1, req_ready=0 throughout; accept on release, next grant the following cycle.
- Flags: a=0x7F7FFFFF + b=0x7F7FFFFF -> rsp_flags overflow+inexact set, sticky_flags matches; flags_clr asserted on the next capture cycle of 1.0+1.0 -> sticky_flags=0.
- Reset mid-EVAL with EVAL_CYCLES=3 -> next cycle state IDLE, rsp_valid=0, rr_ptr=0, no response for dropped op; requester 0 granted first afterward.
- Pointer wrap: only req3 valid then only req0 -> grants 3 then 0; rr_ptr=0 then 1.
